instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder counterpart of the opcode control decoder. Accepts symbolic instruction requests
//  (class + register fields + immediate) over valid/ready and assembles RV32I words
//  (R-type 0110011, LW 0000011, SW 0100011, BEQ 1100011) that the decoder understands.
//  Writes the words sequentially into instruction memory through a held write port.
//  Used by bring-up benches and the boot loader to fill program memory.
// PARAMETERS
//  ADDR_W  8  word-address width of the instruction memory; capacity = 2**ADDR_W words
// PORTS
//  clk         in   1         clock, rising edge
//  reset       in   1         asynchronous, active-high reset
//  start       in   1         pulse: open a load session at word 0, clear count/err
//  finish      in   1         pulse: close session after pending write drains
//  req_valid   in   1         request valid
//  req_ready   out  1         request accepted when req_valid & req_ready
//  req_kind    in   2         00 R-type, 01 LW, 10 SW, 11 BEQ
//  req_funct3  in   3         R-type funct3 (ignored otherwise: LW/SW=010, BEQ=000)
//  req_f7_5    in   1         R-type funct7[5] (SUB/SRA); other funct7 bits are 0
//  req_rd      in   5         destination (R, LW)
//  req_rs1     in   5         source 1 (all kinds)
//  req_rs2     in   5         source 2 (R, SW, BEQ)
//  req_imm     in   13        signed immediate: LW/SW use [11:0], BEQ byte offset [12:0]
//  mem_we      out  1         write request to instruction memory, held until mem_ready
//  mem_ready   in   1         memory accepts write this cycle when mem_we & mem_ready
//  mem_addr    out  ADDR_W    word address of the pending write
//  mem_wdata   out  32        encoded instruction word
//  count       out  ADDR_W+1  words committed this session
//  busy        out  1         session open (state LOAD or FULL)
//  full        out  1         state FULL
//  err         out  1         sticky: a request was rejected; cleared by start
//  done        out  1         one-cycle pulse on LOAD/FULL -> IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; write address 0; any pending write dropped.
//  FSM: IDLE --start--> LOAD; LOAD --last word committed--> FULL;
//   LOAD/FULL --finish (latched until mem_we clear)--> IDLE with done pulse;
//   start in LOAD/FULL re-opens the session: addr=0, count=0, err=0, pending write dropped.
//  req_ready = (state==LOAD) & ~start & ~finish_pend & (~mem_we | mem_ready) & ~addr_exhausted.
//  Latency: accepted request -> mem_we/mem_addr/mem_wdata registered next cycle (1 cycle);
//   back-to-back throughput 1 word/cycle while mem_ready=1; mem outputs stable while stalled.
//  Encoding: R {0,f7_5,00000,rs2,rs1,funct3,rd,0110011}; LW {imm[11:0],rs1,010,rd,0000011};
//   SW {imm[11:5],rs2,rs1,010,imm[4:0],0100011};
//   BEQ {imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011}.
//  Rejection (request consumed, no write, err<=1, addr/count unchanged):
//   LW/SW with imm[12]!=imm[11]; BEQ with imm[0]=1.
//  On write commit (mem_we & mem_ready): count+1, addr+1; committing addr 2**ADDR_W-1 -> FULL,
//   addr does not wrap; requests in FULL are not accepted (req_ready=0).
//  start and finish same cycle: start wins. start in IDLE with req_valid: nothing accepted
//   that cycle. finish in IDLE: ignored, no done.
// STRUCTURE
//  Shared package: req_kind codes, RV32I opcode constants (OP_R/OP_LW/OP_SW/OP_BEQ),
//   funct3 constants, FSM state encoding (shared with decoder tests).
//  Sub-module rv32_instr_encode: purely combinational kind/fields/imm -> {word, illegal}.
//  Top holds FSM, address/count registers, held write-port register.
// TESTING
//  R add rd=3,rs1=1,rs2=2,f3=0 -> mem_wdata 0x002081B3 at addr 0, one cycle after accept.
//  LW rd=5,rs1=2,imm=8 then SW rs2=5,rs1=2,imm=12 -> 0x00812283 @0, 0x00512623 @1, count=2.
//  BEQ rs1=1,rs2=2,imm=0x1FF8 (-8) -> 0xFE208CE3; BEQ imm=0x0003 -> no write, err=1.
//  ADDR_W=2: 5 back-to-back requests, mem_ready=1 -> 4 writes @0..3, full=1, 5th held (ready=0).
//  mem_ready low 3 cycles mid-stream -> mem_addr/wdata stable, req_ready=0, no word lost.
//  Assert reset with mem_we pending -> mem_we=0 immediately, state IDLE; finish -> done pulse 1 cycle.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// instr_encoder_loader_pkg: request kinds, RV32I opcode/funct3 constants and loader FSM states
package instr_encoder_loader_pkg;
    typedef enum logic [1:0] {K_R = 2'b00, K_LW = 2'b01, K_SW = 2'b10, K_BEQ = 2'b11} kind_t;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [2:0] F3_LSW = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_LOAD = 2'b01, S_FULL = 2'b10} state_t;
endpackage

// File: rtl/instr_encoder_loader_encode.sv
// rv32_instr_encode: combinational symbolic request -> RV32I word plus illegal-immediate flag
module rv32_instr_encode
    import instr_encoder_loader_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [2:0]  funct3,
    input  logic        f7_5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    always_comb begin
        word = kind == K_R  ? {1'b0, f7_5, 5'b0, rs2, rs1, funct3, rd, OP_R} :
               kind == K_LW ? {imm[11:0], rs1, F3_LSW, rd, OP_LW} :
               kind == K_SW ? {imm[11:5], rs2, rs1, F3_LSW, imm[4:0], OP_SW} :
                              {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BEQ};
        // LW/SW immediates must fit 12 signed bits; branch offsets must be halfword aligned
        illegal = (kind == K_LW || kind == K_SW) ? imm[12] ^ imm[11] :
                  kind == K_BEQ ? imm[0] : 1'b0;
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes instruction requests and streams them into instruction memory
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [2:0]        req_funct3,
    input  logic              req_f7_5,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err,
    output logic              done
);
    state_t state, state_n;
    logic finish_pend, commit, last, accept, leave, illegal;
    logic [31:0] word;

    rv32_instr_encode u_enc (
        .kind(req_kind), .funct3(req_funct3), .f7_5(req_f7_5), .rd(req_rd),
        .rs1(req_rs1), .rs2(req_rs2), .imm(req_imm), .word(word), .illegal(illegal)
    );

    // mem_addr doubles as the write pointer; it advances only on commit
    always_comb begin
        commit    = mem_we & mem_ready;
        last      = mem_addr == {ADDR_W{1'b1}};
        req_ready = state == S_LOAD && !start && !finish_pend && (!mem_we || mem_ready) && !(mem_we && last);
        accept    = req_valid & req_ready;
        leave     = !start && state != S_IDLE && (finish || finish_pend) && !mem_we;
        state_n   = start ? S_LOAD :
                    leave ? S_IDLE :
                    (state == S_LOAD && commit && last) ? S_FULL : state;
        busy      = state != S_IDLE;
        full      = state == S_FULL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            count       <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            finish_pend <= 1'b0;
        end else begin
            done <= leave;
            if (start) begin
                mem_we      <= 1'b0;
                mem_addr    <= '0;
                count       <= '0;
                err         <= 1'b0;
                finish_pend <= 1'b0;
            end else begin
                finish_pend <= leave ? 1'b0 : (finish_pend | (finish & busy));
                if (commit) begin
                    count <= count + 1'b1;
                    if (!last) mem_addr <= mem_addr + 1'b1;
                end
                if (accept && !illegal) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= word;
                end else if (commit) mem_we <= 1'b0;
                if (accept && illegal) err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed vectors against hand-encoded RV32I words, using a 4-word memory
module tb_instr_encoder_loader;
    localparam int AW = 2;
    logic clk = 0, reset = 1, start = 0, finish = 0, req_valid = 0, mem_ready = 0;
    logic req_ready, mem_we, busy, full, err, done, req_f7_5 = 0;
    logic [1:0] req_kind = 0;
    logic [2:0] req_funct3 = 0;
    logic [4:0] req_rd = 0, req_rs1 = 0, req_rs2 = 0;
    logic [12:0] req_imm = 0;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [AW:0] count;
    int tests = 0, fails = 0;
    bit ok;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish), .req_valid(req_valid),
        .req_ready(req_ready), .req_kind(req_kind), .req_funct3(req_funct3), .req_f7_5(req_f7_5),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .busy(busy), .full(full), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // called at a falling edge; returns at the falling edge after acceptance or after lim cycles
    task automatic push(input logic [1:0] k, input logic [2:0] f3, input logic f75, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                        input int lim, output bit acc);
        req_kind = k; req_funct3 = f3; req_f7_5 = f75; req_rd = rd;
        req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_valid = 1;
        acc = 0;
        for (int i = 0; i < lim && !acc; i++) begin
            #1 acc = req_ready;
            @(negedge clk);
        end
        req_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        @(negedge clk);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_ready", req_ready, 0);
        reset = 0;
        @(negedge clk);
        finish = 1;
        @(negedge clk);
        finish = 0;
        @(negedge clk);
        check("idle_finish_done", done, 0);
        start = 1; req_valid = 1;
        #1 check("start_blocks_ready", req_ready, 0);
        @(negedge clk);
        start = 0; req_valid = 0;
        check("busy_after_start", busy, 1);
        mem_ready = 1;
        push(2'b00, 3'b000, 0, 5'd3, 5'd1, 5'd2, 13'd0, 4, ok);
        check("r_acc", ok, 1);
        check("r_we", mem_we, 1);
        check("r_addr", mem_addr, 0);
        check("r_word", mem_wdata, 32'h002081B3);
        @(negedge clk);
        check("r_count", count, 1);
        check("r_we_clear", mem_we, 0);

        pulse_start();
        check("restart_count", count, 0);
        push(2'b01, 3'b111, 0, 5'd5, 5'd2, 5'd0, 13'd8, 4, ok);
        check("lw_word", mem_wdata, 32'h00812283);
        check("lw_addr", mem_addr, 0);
        push(2'b10, 3'b000, 0, 5'd0, 5'd2, 5'd5, 13'd12, 4, ok);
        check("sw_acc", ok, 1);
        check("sw_word", mem_wdata, 32'h00512623);
        check("sw_addr", mem_addr, 1);
        push(2'b11, 3'b000, 0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 4, ok);
        check("beq_word", mem_wdata, 32'hFE208CE3);
        check("beq_addr", mem_addr, 2);
        push(2'b11, 3'b000, 0, 5'd0, 5'd1, 5'd2, 13'h0003, 4, ok);
        check("beq_odd_acc", ok, 1);
        check("beq_odd_nowrite", mem_we, 0);
        check("beq_odd_err", err, 1);
        check("beq_odd_count", count, 3);
        push(2'b01, 3'b000, 0, 5'd1, 5'd1, 5'd0, 13'h0800, 4, ok);
        check("lw_range_nowrite", mem_we, 0);
        check("lw_range_count", count, 3);

        pulse_start();
        check("start_clr_err", err, 0);
        push(2'b00, 3'b000, 1, 5'd7, 5'd8, 5'd9, 13'd0, 4, ok);
        check("sub_word", mem_wdata, 32'h409403B3);
        mem_ready = 0;
        req_kind = 2'b00; req_funct3 = 3'b111; req_f7_5 = 0;
        req_rd = 5'd1; req_rs1 = 5'd2; req_rs2 = 5'd3; req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", req_ready, 0);
            check("stall_addr", mem_addr, 0);
            check("stall_word", mem_wdata, 32'h409403B3);
            @(negedge clk);
        end
        mem_ready = 1;
        #1 check("unstall_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        check("unstall_addr", mem_addr, 1);
        check("unstall_word", mem_wdata, 32'h003170B3);
        check("unstall_count", count, 1);
        @(negedge clk);
        check("stream_count", count, 2);

        pulse_start();
        for (int i = 0; i < 4; i++) begin
            push(2'b00, 3'b000, 0, 5'(i), 5'd0, 5'd0, 13'd0, 4, ok);
            check("fill_acc", ok, 1);
            check("fill_addr", mem_addr, i);
        end
        push(2'b00, 3'b000, 0, 5'd9, 5'd0, 5'd0, 13'd0, 4, ok);
        check("fifth_rejected", ok, 0);
        check("full_flag", full, 1);
        check("full_count", count, 4);
        check("full_addr", mem_addr, 3);
        check("full_we", mem_we, 0);

        pulse_start();
        mem_ready = 0;
        push(2'b00, 3'b000, 0, 5'd1, 5'd0, 5'd0, 13'd0, 4, ok);
        check("pend_we", mem_we, 1);
        #2 reset = 1;
        #1;
        check("async_rst_we", mem_we, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        reset = 0;

        pulse_start();
        push(2'b00, 3'b000, 0, 5'd1, 5'd0, 5'd0, 13'd0, 4, ok);
        finish = 1;
        @(negedge clk);
        finish = 0;
        check("fin_wait_busy", busy, 1);
        check("fin_wait_done", done, 0);
        @(negedge clk);
        mem_ready = 1;
        @(negedge clk);
        check("fin_drained", mem_we, 0);
        check("fin_drain_busy", busy, 1);
        @(negedge clk);
        check("fin_idle", busy, 0);
        check("fin_done", done, 1);
        check("fin_count", count, 1);
        @(negedge clk);
        check("fin_done_pulse", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
